eig_seq_ctrl: RTL and testbench
===============================

Name: eig_seq_ctrl

Overview:
- Central sequencer between param_loader, eig_core and output_loader in the watchdog top level.
- Accepts a validated operand pair (a0, a1) and latches it. Launches one eig_core computation and captures kappa/inv_kappa/regime when the core finishes.
- Hands the captured results to output_loader and holds the loader off while a job is in flight.
- Supervises every handshake with cycle timeouts and reports a hang through a sticky error flag.

Parameters:
ACK_TO, 15, max cycles from core_start/ol_start to the busy rise
RUN_TO, 1023, max cycles core_busy may stay high
OUT_TO, 511, max cycles ol_busy may stay high
CW, 10, timeout counter width; must satisfy 2^CW > max(ACK_TO, RUN_TO, OUT_TO)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes the FSM
params_vld  in  1  1-cycle pulse from param_loader: a0_in/a1_in valid
a0_in  in  32  signed operand alpha
a1_in  in  32  signed operand beta
ctrl_busy  out  1  high whenever state != IDLE; drives param_loader core_busy
core_start  out  1  1-cycle launch pulse to eig_core
core_a0  out  32  latched alpha to core
core_a1  out  32  latched beta to core
core_busy  in  1  eig_core busy
core_kappa  in  32  core result K
core_inv_kappa  in  32  core result 1/K
core_regime  in  3  core regime code
ol_start  out  1  1-cycle start pulse to output_loader
ol_wordA  out  32  latched K
ol_wordB  out  32  latched invK
ol_mode  out  3  latched regime; 3'b111 = error frame
ol_busy  in  1  output_loader busy
done  out  1  1-cycle pulse when a job completes, normal or error
err  out  1  sticky timeout flag
err_code  out  2  00 none, 01 ack timeout, 10 core run timeout, 11 output timeout

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; counter = 0.
  - All outputs are 0, including all 32-bit registers and err_code.
- ena low:
  - State, counter and latched registers hold.
  - core_start, ol_start and done are forced to 0.
  - params_vld is ignored.
- Counter: cleared on every state change, increments each enabled cycle spent in a WAIT state.
- Timeout: in a WAIT state, the cycle on which the counter equals the limit without the awaited edge causes a transition to ERR on the next cycle.
- States and transitions:
  - IDLE: on params_vld, latch core_a0 <= a0_in and core_a1 <= a1_in, clear err and err_code, then go to LAUNCH. params_vld arriving in any other state is dropped and does not affect the current job.
  - LAUNCH: core_start = 1 for exactly this cycle; go to C_ACK.
  - C_ACK: core_busy = 1 -> C_RUN; counter == ACK_TO -> ERR, err_code = 01.
  - C_RUN: core_busy = 0 -> CAPT; counter == RUN_TO -> ERR, err_code = 10.
  - CAPT: ol_wordA <= core_kappa, ol_wordB <= core_inv_kappa, ol_mode <= core_regime; go to O_LAUNCH.
  - O_LAUNCH: ol_start = 1 for one cycle; go to O_ACK.
  - O_ACK: ol_busy = 1 -> O_RUN; counter == ACK_TO -> ERR, err_code = 01.
  - O_RUN: ol_busy = 0 -> IDLE with done = 1 on that transition cycle; counter == OUT_TO -> ERR, err_code = 11.
  - ERR:
    - Set err = 1 (sticky until the next accepted params_vld or reset).
    - Load ol_wordA = 0, ol_wordB = 0, ol_mode = 3'b111.
    - If the timeout came from an output state, go to IDLE with done = 1 and do not restart the loader.
    - Otherwise go to O_LAUNCH, so the error frame is emitted once.
- Latency, ideal handshakes (core asserts busy 1 cycle after start, output_loader likewise):
  - params_vld to core_start: 1 cycle.
  - core_busy fall to ol_start: 2 cycles.
- core_busy already high in IDLE does not matter; C_ACK sees it at once and enters C_RUN.
- core_busy may fall and rise again on the cycle CAPT is entered; the results are taken in CAPT regardless.
- Width rules: no arithmetic on data; results are passed through bit-exact, with no sign or width change.
- ctrl_busy is combinational from state only, with no glitch paths from inputs.

Test Plan:
- Nominal job:
  - Stimulus: params_vld with a0 = 32'h0001_0000, a1 = 32'hFFFF_8000; core answers busy for 20 cycles with K = 32'h0002_0000, invK = 32'h0000_8000, regime = 3'b010; output_loader is busy for 8 cycles.
  - Response: core_start 1 cycle after params_vld; ol_start 2 cycles after the core_busy fall; ol_wordA/B and ol_mode match the core results; one done pulse; err = 0.
- Ack timeout:
  - Stimulus: core_busy never rises.
  - Response: ERR entered 16 cycles after C_ACK entry; err = 1, err_code = 01; ol_start with ol_mode = 111 and both words 0.
- Run timeout: core_busy held high for more than 1024 cycles -> err_code = 10, one error frame, done pulse, ctrl_busy returns to 0.
- Output timeout: ol_busy stuck high -> err_code = 11, no second ol_start, done pulse, return to IDLE.
- Freeze and drop:
  - Stimulus: drop ena for 50 cycles mid C_RUN while core_busy falls; issue a second params_vld during O_RUN.
  - Response: no progress while ena = 0; CAPT follows 1 cycle after ena returns; the second params_vld is ignored.
- Reset mid-job: rst_n asserted in O_RUN -> all outputs 0 asynchronously; a fresh job after reset completes normally.

Source files
------------

// File: rtl/eig_seq_ctrl.sv
// rtl/eig_seq_ctrl.sv - job sequencer between param_loader, eig_core and output_loader
module eig_seq_ctrl #(
   parameter int ACK_TO = 15,
   parameter int RUN_TO = 1023,
   parameter int OUT_TO = 511,
   parameter int CW     = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        params_vld,
   input  logic [31:0] a0_in,
   input  logic [31:0] a1_in,
   output logic        ctrl_busy,
   output logic        core_start,
   output logic [31:0] core_a0,
   output logic [31:0] core_a1,
   input  logic        core_busy,
   input  logic [31:0] core_kappa,
   input  logic [31:0] core_inv_kappa,
   input  logic [2:0]  core_regime,
   output logic        ol_start,
   output logic [31:0] ol_wordA,
   output logic [31:0] ol_wordB,
   output logic [2:0]  ol_mode,
   input  logic        ol_busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [3:0] {
      S_IDLE, S_LAUNCH, S_C_ACK, S_C_RUN, S_CAPT,
      S_O_LAUNCH, S_O_ACK, S_O_RUN, S_ERR
   } state_t;

   localparam logic [CW-1:0] ACK_LIM = CW'(ACK_TO);
   localparam logic [CW-1:0] RUN_LIM = CW'(RUN_TO);
   localparam logic [CW-1:0] OUT_LIM = CW'(OUT_TO);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          err_from_out;   // timeout came from the loader, so no error frame is sent

   // Any non-idle state means a job owns the core and the loader.
   assign ctrl_busy = (state != S_IDLE);

   // Sequencer: state, timeout counter, latched operands/results and registered pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         err_from_out <= 1'b0;
         core_start   <= 1'b0;
         core_a0      <= '0;
         core_a1      <= '0;
         ol_start     <= 1'b0;
         ol_wordA     <= '0;
         ol_wordB     <= '0;
         ol_mode      <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= '0;
      end else if (!ena) begin
         core_start <= 1'b0;
         ol_start   <= 1'b0;
         done       <= 1'b0;
      end else begin
         core_start <= 1'b0;
         ol_start   <= 1'b0;
         done       <= 1'b0;
         cnt        <= '0;
         case (state)
            S_IDLE: begin
               if (params_vld) begin
                  core_a0    <= a0_in;
                  core_a1    <= a1_in;
                  err        <= 1'b0;
                  err_code   <= 2'b00;
                  core_start <= 1'b1;
                  state      <= S_LAUNCH;
               end
            end
            S_LAUNCH: state <= S_C_ACK;
            S_C_ACK: begin
               if (core_busy) begin
                  state <= S_C_RUN;
               end else if (cnt == ACK_LIM) begin
                  state        <= S_ERR;
                  err          <= 1'b1;
                  err_code     <= 2'b01;
                  err_from_out <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_C_RUN: begin
               if (!core_busy) begin
                  state <= S_CAPT;
               end else if (cnt == RUN_LIM) begin
                  state        <= S_ERR;
                  err          <= 1'b1;
                  err_code     <= 2'b10;
                  err_from_out <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CAPT: begin
               ol_wordA <= core_kappa;
               ol_wordB <= core_inv_kappa;
               ol_mode  <= core_regime;
               ol_start <= 1'b1;
               state    <= S_O_LAUNCH;
            end
            S_O_LAUNCH: state <= S_O_ACK;
            S_O_ACK: begin
               if (ol_busy) begin
                  state <= S_O_RUN;
               end else if (cnt == ACK_LIM) begin
                  state        <= S_ERR;
                  err          <= 1'b1;
                  err_code     <= 2'b01;
                  err_from_out <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_O_RUN: begin
               if (!ol_busy) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end else if (cnt == OUT_LIM) begin
                  state        <= S_ERR;
                  err          <= 1'b1;
                  err_code     <= 2'b11;
                  err_from_out <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ERR: begin
               err      <= 1'b1;
               ol_wordA <= '0;
               ol_wordB <= '0;
               ol_mode  <= 3'b111;
               if (err_from_out) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end else begin
                  state    <= S_O_LAUNCH;
                  ol_start <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eig_seq_ctrl.sv
// tb/tb_eig_seq_ctrl.sv - self-checking bench for eig_seq_ctrl
module tb_eig_seq_ctrl;

   localparam int ACK_TO = 15;
   localparam int RUN_TO = 1023;
   localparam int OUT_TO = 511;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        params_vld = 1'b0;
   logic [31:0] a0_in = '0;
   logic [31:0] a1_in = '0;
   logic        core_busy = 1'b0;
   logic [31:0] core_kappa = '0;
   logic [31:0] core_inv_kappa = '0;
   logic [2:0]  core_regime = '0;
   logic        ol_busy = 1'b0;

   logic        ctrl_busy, core_start, ol_start, done, err;
   logic [31:0] core_a0, core_a1, ol_wordA, ol_wordB;
   logic [2:0]  ol_mode;
   logic [1:0]  err_code;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   eig_seq_ctrl #(.ACK_TO(ACK_TO), .RUN_TO(RUN_TO), .OUT_TO(OUT_TO), .CW(10)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .params_vld(params_vld),
      .a0_in(a0_in), .a1_in(a1_in), .ctrl_busy(ctrl_busy),
      .core_start(core_start), .core_a0(core_a0), .core_a1(core_a1),
      .core_busy(core_busy), .core_kappa(core_kappa),
      .core_inv_kappa(core_inv_kappa), .core_regime(core_regime),
      .ol_start(ol_start), .ol_wordA(ol_wordA), .ol_wordB(ol_wordB),
      .ol_mode(ol_mode), .ol_busy(ol_busy), .done(done), .err(err),
      .err_code(err_code)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ctrl_busy"}, 32'(ctrl_busy), 32'd0);
      chk({tag, " core_start"}, 32'(core_start), 32'd0);
      chk({tag, " core_a0"}, core_a0, 32'd0);
      chk({tag, " core_a1"}, core_a1, 32'd0);
      chk({tag, " ol_start"}, 32'(ol_start), 32'd0);
      chk({tag, " ol_wordA"}, ol_wordA, 32'd0);
      chk({tag, " ol_wordB"}, ol_wordB, 32'd0);
      chk({tag, " ol_mode"}, 32'(ol_mode), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " err"}, 32'(err), 32'd0);
      chk({tag, " err_code"}, 32'(err_code), 32'd0);
   endtask

   // One job. The core acknowledges after w_ack idle cycles and stays busy r_run cycles;
   // the loader likewise with w_ol / r_ol. Timing is counted in cycles after core_start.
   task automatic run_job(input int w_ack, input int r_run, input int w_ol, input int r_ol,
                          input bit drop, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] k, input logic [31:0] ik, input logic [2:0] rg);
      int core_fail, ol_fail, t_ol, t_done, t_drop;
      logic [31:0] fa, fb;
      logic [2:0]  fm;
      logic [1:0]  ecode;
      if (w_ack > ACK_TO) begin
         core_fail = 1; t_ol = ACK_TO + 3;
      end else if (r_run > RUN_TO) begin
         core_fail = 2; t_ol = w_ack + RUN_TO + 4;
      end else begin
         core_fail = 0; t_ol = w_ack + r_run + 4;
      end
      if (w_ol > ACK_TO) begin
         ol_fail = 1; t_done = t_ol + ACK_TO + 3;
      end else if (r_ol > OUT_TO) begin
         ol_fail = 2; t_done = t_ol + w_ol + OUT_TO + 4;
      end else begin
         ol_fail = 0; t_done = t_ol + w_ol + r_ol + 3;
      end
      fa = (core_fail == 0) ? k : 32'd0;
      fb = (core_fail == 0) ? ik : 32'd0;
      fm = (core_fail == 0) ? rg : 3'b111;
      if (ol_fail == 1)        ecode = 2'b01;
      else if (ol_fail == 2)   ecode = 2'b11;
      else if (core_fail == 1) ecode = 2'b01;
      else if (core_fail == 2) ecode = 2'b10;
      else                     ecode = 2'b00;
      t_drop = drop ? int'($urandom_range(t_done - 1, 1)) : -1;

      params_vld = 1'b1; a0_in = a0; a1_in = a1;
      core_kappa = $urandom; core_inv_kappa = $urandom; core_regime = 3'($urandom);
      for (int t = 0; t <= t_done + 1; t++) begin
         tick;
         chk("core_start", 32'(core_start), 32'(t == 0));
         chk("ol_start", 32'(ol_start), 32'(t == t_ol));
         chk("done", 32'(done), 32'(t == t_done));
         chk("ctrl_busy", 32'(ctrl_busy), 32'(t < t_done));
         if (t == 0) begin
            chk("core_a0", core_a0, a0);
            chk("core_a1", core_a1, a1);
            chk("err_cleared", 32'(err), 32'd0);
            chk("err_code_cleared", 32'(err_code), 32'd0);
         end
         if (t == t_ol) begin
            chk("frame_wordA", ol_wordA, fa);
            chk("frame_wordB", ol_wordB, fb);
            chk("frame_mode", 32'(ol_mode), 32'(fm));
         end
         if (t == t_done) begin
            chk("err", 32'(err), 32'(ecode != 2'b00));
            chk("err_code", 32'(err_code), 32'(ecode));
            chk("core_a0_kept", core_a0, a0);
            chk("end_wordA", ol_wordA, (ol_fail != 0) ? 32'd0 : fa);
            chk("end_mode", 32'(ol_mode), (ol_fail != 0) ? 32'd7 : 32'(fm));
         end
         params_vld = (t == t_drop);
         if (t == t_drop) begin
            a0_in = ~a0; a1_in = $urandom;
         end
         if (core_fail == 1)      core_busy = 1'b0;
         else if (core_fail == 2) core_busy = (t >= 1 + w_ack) && (t < t_ol);
         else                     core_busy = (t >= 1 + w_ack) && (t <= 1 + w_ack + r_run);
         if (core_fail == 0 && t == 2 + w_ack + r_run) begin
            core_kappa = k; core_inv_kappa = ik; core_regime = rg;
         end else if (t == t_ol) begin
            core_kappa = $urandom; core_inv_kappa = $urandom; core_regime = 3'($urandom);
         end
         if (ol_fail == 1)      ol_busy = 1'b0;
         else if (ol_fail == 2) ol_busy = (t >= t_ol + 1 + w_ol) && (t < t_done);
         else                   ol_busy = (t >= t_ol + 1 + w_ol) && (t <= t_ol + 1 + w_ol + r_ol);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a0, k;
      // reset state
      repeat (3) tick;
      chk_all_zero("reset");
      rst_n = 1'b1; ena = 1'b1;
      repeat (2) tick;

      // nominal job
      run_job(0, 20, 0, 8, 1'b0, 32'h0001_0000, 32'hFFFF_8000,
              32'h0002_0000, 32'h0000_8000, 3'b010);
      // ack boundaries: last in-time ack, then the first timeout
      run_job(ACK_TO, 3, 1, 2, 1'b0, $urandom, $urandom, $urandom, $urandom, 3'b001);
      run_job(ACK_TO + 1, 0, 0, 4, 1'b0, $urandom, $urandom, $urandom, $urandom, 3'b011);
      // run boundaries
      run_job(2, RUN_TO, 0, 1, 1'b0, $urandom, $urandom, $urandom, $urandom, 3'b100);
      run_job(1, RUN_TO + 1, 0, 3, 1'b1, $urandom, $urandom, $urandom, $urandom, 3'b101);
      // output handshake timeouts
      run_job(0, 5, 0, OUT_TO + 1, 1'b0, $urandom, $urandom, $urandom, $urandom, 3'b110);
      run_job(0, 5, ACK_TO + 1, 0, 1'b0, $urandom, $urandom, $urandom, $urandom, 3'b000);
      run_job(0, 5, ACK_TO, OUT_TO, 1'b0, $urandom, $urandom, $urandom, $urandom, 3'b010);

      // randomized jobs
      for (int n = 0; n < 14; n++) begin
         run_job(int'($urandom_range(ACK_TO + 2, 0)), int'($urandom_range(30, 0)),
                 int'($urandom_range(ACK_TO + 2, 0)), int'($urandom_range(20, 0)),
                 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                 3'($urandom_range(6, 0)));
      end

      // freeze while the core finishes, then a dropped params_vld during the output run
      a0 = $urandom; k = $urandom;
      params_vld = 1'b1; a0_in = a0; a1_in = $urandom;
      tick;
      chk("frz core_start", 32'(core_start), 32'd1);
      params_vld = 1'b0; core_busy = 1'b1;
      repeat (10) tick;
      ena = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick;
         chk("frz ol_start", 32'(ol_start), 32'd0);
         chk("frz done", 32'(done), 32'd0);
         chk("frz ctrl_busy", 32'(ctrl_busy), 32'd1);
         if (i == 5) begin
            core_busy = 1'b0; core_kappa = k; core_inv_kappa = ~k; core_regime = 3'b011;
         end
      end
      ena = 1'b1;
      tick;
      chk("frz capt ol_start", 32'(ol_start), 32'd0);
      tick;
      chk("frz ol_start after", 32'(ol_start), 32'd1);
      chk("frz wordA", ol_wordA, k);
      chk("frz wordB", ol_wordB, ~k);
      chk("frz mode", 32'(ol_mode), 32'd3);
      core_kappa = $urandom; ol_busy = 1'b1;
      repeat (3) tick;
      params_vld = 1'b1; a0_in = ~a0;
      tick;
      params_vld = 1'b0;
      repeat (3) tick;
      ol_busy = 1'b0;
      tick;
      chk("drop done", 32'(done), 32'd1);
      chk("drop core_a0", core_a0, a0);
      chk("drop err", 32'(err), 32'd0);
      tick;
      chk("drop no relaunch", 32'(ctrl_busy), 32'd0);
      chk("drop no core_start", 32'(core_start), 32'd0);

      // asynchronous reset in the middle of the output run
      params_vld = 1'b1; a0_in = $urandom; a1_in = $urandom;
      tick;
      params_vld = 1'b0; core_busy = 1'b1;
      repeat (3) tick;
      core_busy = 1'b0; core_kappa = 32'hDEAD_BEEF; core_inv_kappa = 32'h1234_5678;
      core_regime = 3'b101;
      repeat (2) tick;
      chk("rst ol_start", 32'(ol_start), 32'd1);
      ol_busy = 1'b1;
      repeat (4) tick;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      ol_busy = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      run_job(1, 6, 2, 5, 1'b0, $urandom, $urandom, $urandom, $urandom, 3'b001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
